// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - register file dump scan engine streaming {address, data} beats
//
// Walks register addresses in order on the register file Rs port, captures the
// combinational busA value one cycle later and offers it as a beat.
//
// Ports:
//   Clk      clock, rising edge
//   Rst_n    asynchronous active-low reset
//   Start    begin a dump (sampled only in IDLE)
//   Abort    synchronous cancel from any non-IDLE state
//   RdData   register file busA read data
//   RdAddr   registered address to register file Rs port
//   Busy     dump in progress; top level steers Rs and blocks RegWr with it
//   DataOut  beat data
//   AddrOut  beat address
//   Valid    beat valid
//   Ready    sink accepts beat
//   Last     beat carries the final address
//   Done     one-cycle pulse after the final beat is accepted
module regfile_dump_reader #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int SKIP_R0 = 0
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Start,
  input  logic          Abort,
  input  logic [DW-1:0] RdData,
  output logic [AW-1:0] RdAddr,
  output logic          Busy,
  output logic [DW-1:0] DataOut,
  output logic [AW-1:0] AddrOut,
  output logic          Valid,
  input  logic          Ready,
  output logic          Last,
  output logic          Done
);

  localparam logic [AW-1:0] FIRST_ADDR = (SKIP_R0 != 0) ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NREG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_SEND,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] rd_addr_n;
  logic [AW-1:0] addr_out_n;
  logic [DW-1:0] data_out_n;
  logic          busy_n;
  logic          valid_n;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= S_IDLE;
      RdAddr  <= '0;
      Busy    <= 1'b0;
      DataOut <= '0;
      AddrOut <= '0;
      Valid   <= 1'b0;
    end else begin
      state   <= state_n;
      RdAddr  <= rd_addr_n;
      Busy    <= busy_n;
      DataOut <= data_out_n;
      AddrOut <= addr_out_n;
      Valid   <= valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    rd_addr_n  = RdAddr;
    busy_n     = Busy;
    data_out_n = DataOut;
    addr_out_n = AddrOut;
    valid_n    = Valid;

    case (state)
      S_IDLE: begin
        if (Start && !Abort) begin
          state_n   = S_ADDR;
          rd_addr_n = FIRST_ADDR;
          busy_n    = 1'b1;
        end
      end
      S_ADDR: begin
        // RdAddr has been stable for a full cycle, so busA has settled.
        data_out_n = RdData;
        addr_out_n = RdAddr;
        valid_n    = 1'b1;
        state_n    = S_SEND;
      end
      S_SEND: begin
        if (Ready) begin
          valid_n = 1'b0;
          if (AddrOut == LAST_ADDR) begin
            state_n = S_DONE;
          end else begin
            // Only reached below LAST_ADDR, so the counter never wraps.
            rd_addr_n = RdAddr + AW'(1);
            state_n   = S_ADDR;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        valid_n = 1'b0;
      end
    endcase

    // Abort overrides both the handshake and any pending state change.
    if (Abort && (state != S_IDLE)) begin
      state_n    = S_IDLE;
      rd_addr_n  = RdAddr;
      data_out_n = DataOut;
      addr_out_n = AddrOut;
      busy_n     = 1'b0;
      valid_n    = 1'b0;
    end
  end

  assign Last = Valid && (AddrOut == LAST_ADDR);
  assign Done = (state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst_n, start0, start1, Abort, Ready, sel;
  logic [DW-1:0] mem [NREG];

  logic [AW-1:0] addr0, addr1, aout0, aout1;
  logic [DW-1:0] rd0, rd1, dout0, dout1;
  logic busy0, busy1, valid0, valid1, last0, last1, done0, done1;

  assign rd0 = mem[addr0];
  assign rd1 = mem[addr1];

  regfile_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW), .SKIP_R0(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(start0), .Abort(Abort), .RdData(rd0),
    .RdAddr(addr0), .Busy(busy0), .DataOut(dout0), .AddrOut(aout0),
    .Valid(valid0), .Ready(Ready), .Last(last0), .Done(done0)
  );

  regfile_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW), .SKIP_R0(1)) dut_skip (
    .Clk(Clk), .Rst_n(Rst_n), .Start(start1), .Abort(Abort), .RdData(rd1),
    .RdAddr(addr1), .Busy(busy1), .DataOut(dout1), .AddrOut(aout1),
    .Valid(valid1), .Ready(Ready), .Last(last1), .Done(done1)
  );

  wire [AW-1:0] m_addr  = sel ? addr1  : addr0;
  wire [AW-1:0] m_aout  = sel ? aout1  : aout0;
  wire [DW-1:0] m_dout  = sel ? dout1  : dout0;
  wire          m_busy  = sel ? busy1  : busy0;
  wire          m_valid = sel ? valid1 : valid0;
  wire          m_last  = sel ? last1  : last0;
  wire          m_done  = sel ? done1  : done0;

  int errors = 0;
  int checks = 0;

  // Observations from one run
  logic [AW-1:0] b_addr[$];
  logic [DW-1:0] b_data[$];
  bit            b_last[$];
  int first_valid, done_cnt, done_cycle, busy_fall, last_idle_bad;
  int stall_samples, unstable, rst_bad, rst_active;
  bit ab_valid, ab_busy, ab_done, finished;

  // Reference: every address from the first one up to NREG-1, in order, with its stored word
  logic [AW-1:0] e_addr[$];
  logic [DW-1:0] e_data[$];

  task automatic build_model(input int first);
    e_addr.delete();
    e_data.delete();
    for (int a = first; a < NREG; a++) begin
      e_addr.push_back(AW'(a));
      e_data.push_back(mem[a]);
    end
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < NREG; i++) mem[i] = rnd ? DW'($urandom) : DW'(32'h1000_0000 + i);
  endtask

  task automatic drive_start(input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask

  function automatic int count_last();
    int n = 0;
    foreach (b_last[i]) if (b_last[i]) n++;
    return n;
  endfunction

  // Starts a dump and watches it cycle by cycle. Cycle 0 is the first negedge after
  // the edge that sampled Start. ready_mode: 0 always ready, 1 random, 2 stall beat 3.
  task automatic run(input bit s, input int ready_mode, input bit hold_start, input int pulse_at,
                     input int abort_at, input int reset_at, input int budget);
    int post;
    bit pulsed, aborted, abort_pending, reset_hit;
    logic [DW-1:0] held_d;
    logic [AW-1:0] held_a;
    b_addr.delete(); b_data.delete(); b_last.delete();
    first_valid = -1; done_cnt = 0; done_cycle = -1; busy_fall = -1; last_idle_bad = 0;
    stall_samples = 0; unstable = 0; rst_bad = 0; rst_active = 0;
    ab_valid = 1; ab_busy = 1; ab_done = 1; finished = 0;
    post = -1; pulsed = 0; aborted = 0; abort_pending = 0; reset_hit = 0;
    held_d = '0; held_a = '0;
    sel = s;
    Ready = 1'b1;
    drive_start(1'b1);
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge Clk);
      if (!hold_start) drive_start(1'b0);
      Abort = 1'b0;
      if (reset_hit && !Rst_n) Rst_n = 1'b1;
      else if (reset_hit && (m_busy || m_valid)) rst_active++;
      if (m_last && !m_valid) last_idle_bad++;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_done) begin
        done_cnt++;
        done_cycle = cyc;
        if (post < 0) post = cyc + (hold_start ? 4 : 2);
      end
      if (busy_fall < 0 && !m_busy) busy_fall = cyc;
      if (abort_pending) begin
        ab_valid = m_valid; ab_busy = m_busy; ab_done = m_done;
        abort_pending = 0;
        post = cyc + 3;
      end
      if (post >= 0 && cyc >= post) begin
        finished = 1;
        break;
      end

      if (ready_mode == 1) begin
        Ready = 1'($urandom_range(0, 1));
      end else if (ready_mode == 2 && m_valid && m_aout == AW'(3)) begin
        if (stall_samples == 0) begin
          held_d = m_dout;
          held_a = m_aout;
        end else if (m_dout !== held_d || m_aout !== held_a) begin
          unstable++;
        end
        stall_samples++;
        Ready = (stall_samples > 5);
      end else begin
        Ready = 1'b1;
      end

      if (reset_at >= 0 && !reset_hit && m_valid && m_aout == AW'(reset_at)) begin
        #2 Rst_n = 1'b0;
        #1 if ({m_addr, m_busy, m_dout, m_aout, m_valid, m_last, m_done} !== '0) rst_bad++;
        reset_hit = 1;
        post = cyc + 4;
      end else begin
        if (abort_at >= 0 && !aborted && m_valid && m_aout == AW'(abort_at)) begin
          Abort = 1'b1;
          Ready = 1'b1;
          aborted = 1;
          abort_pending = 1;
        end else if (m_valid && Ready) begin
          b_addr.push_back(m_aout);
          b_data.push_back(m_dout);
          b_last.push_back(m_last);
        end
        if (pulse_at >= 0 && !pulsed && m_valid && m_aout == AW'(pulse_at)) begin
          drive_start(1'b1);
          pulsed = 1;
        end
      end
    end
    drive_start(1'b0);
    Ready = 1'b1;
    @(negedge Clk) Abort = 1'b1;
    @(negedge Clk) Abort = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; Abort = 1'b0; Ready = 1'b1; sel = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({addr0, busy0, dout0, aout0, valid0, last0, done0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0", {addr0, busy0, dout0, aout0, valid0, last0, done0});
    end
    checks++;
    if ({addr1, busy1, dout1, aout1, valid1, last1, done1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_skip: got %0h expected 0", {addr1, busy1, dout1, aout1, valid1, last1, done1});
    end
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({busy0, valid0, done0} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got busy/valid/done=%b expected 000", {busy0, valid0, done0});
    end
  endtask

  task automatic test_full_dump();
    fill_mem(0);
    build_model(0);
    run(0, 0, 0, -1, -1, -1, 200);
    checks++;
    if (!finished) begin errors++; $display("FAIL full_timeout: got unfinished expected done"); end
    checks++;
    if (b_addr.size() != e_addr.size()) begin
      errors++; $display("FAIL full_count: got %0d expected %0d", b_addr.size(), e_addr.size());
    end
    for (int i = 0; i < e_addr.size() && i < b_addr.size(); i++) begin
      checks++;
      if (b_addr[i] !== e_addr[i] || b_data[i] !== e_data[i]) begin
        errors++;
        $display("FAIL full_beat%0d: got %0h/%0h expected %0h/%0h", i, b_addr[i], b_data[i], e_addr[i], e_data[i]);
      end
    end
    // Start sampled at edge 0, beat visible after edge 1, one beat per two cycles.
    checks++;
    if (first_valid != 1) begin errors++; $display("FAIL full_first_valid: got %0d expected 1", first_valid); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (done_cycle != 2 * NREG) begin
      errors++; $display("FAIL full_done_cycle: got %0d expected %0d", done_cycle, 2 * NREG);
    end
    checks++;
    if (busy_fall != 2 * NREG + 1) begin
      errors++; $display("FAIL full_busy_fall: got %0d expected %0d", busy_fall, 2 * NREG + 1);
    end
    checks++;
    if (count_last() != 1 || b_last.size() == 0 || !b_last[b_last.size() - 1]) begin
      errors++; $display("FAIL full_last: got %0d last beats expected 1 on final", count_last());
    end
    checks++;
    if (last_idle_bad != 0) begin errors++; $display("FAIL full_last_without_valid: got %0d expected 0", last_idle_bad); end
  endtask

  task automatic test_backpressure();
    fill_mem(0);
    build_model(0);
    run(0, 2, 0, -1, -1, -1, 200);
    checks++;
    if (stall_samples != 6) begin errors++; $display("FAIL bp_stall_len: got %0d expected 6", stall_samples); end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
    checks++;
    if (b_addr.size() != NREG || done_cnt != 1) begin
      errors++; $display("FAIL bp_count: got %0d beats %0d done expected %0d/1", b_addr.size(), done_cnt, NREG);
    end
    for (int i = 0; i < e_addr.size() && i < b_addr.size(); i++) begin
      checks++;
      if (b_addr[i] !== e_addr[i] || b_data[i] !== e_data[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: got %0h/%0h expected %0h/%0h", i, b_addr[i], b_data[i], e_addr[i], e_data[i]);
      end
    end
  endtask

  task automatic test_abort();
    fill_mem(1);
    build_model(0);
    run(0, 0, 0, -1, 10, -1, 200);
    checks++;
    if ({ab_valid, ab_busy, ab_done} !== 3'b000) begin
      errors++; $display("FAIL abort_outputs: got valid/busy/done=%b expected 000", {ab_valid, ab_busy, ab_done});
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    checks++;
    if (b_addr.size() != 10) begin errors++; $display("FAIL abort_count: got %0d expected 10", b_addr.size()); end
    for (int i = 0; i < 10 && i < b_addr.size(); i++) begin
      checks++;
      if (b_addr[i] !== e_addr[i] || b_data[i] !== e_data[i]) begin
        errors++;
        $display("FAIL abort_beat%0d: got %0h/%0h expected %0h/%0h", i, b_addr[i], b_data[i], e_addr[i], e_data[i]);
      end
    end
    run(0, 0, 0, -1, -1, -1, 200);
    checks++;
    if (b_addr.size() != NREG || b_addr[0] !== AW'(0) || done_cnt != 1) begin
      errors++; $display("FAIL abort_restart: got %0d beats first %0h expected %0d from 0", b_addr.size(), b_addr[0], NREG);
    end
    for (int i = 0; i < e_addr.size() && i < b_addr.size(); i++) begin
      checks++;
      if (b_addr[i] !== e_addr[i] || b_data[i] !== e_data[i]) begin
        errors++;
        $display("FAIL restart_beat%0d: got %0h/%0h expected %0h/%0h", i, b_addr[i], b_data[i], e_addr[i], e_data[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    fill_mem(1);
    run(0, 0, 0, -1, -1, 7, 200);
    checks++;
    if (rst_bad != 0) begin errors++; $display("FAIL arst_outputs: got %0d nonzero expected 0", rst_bad); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL arst_no_done: got %0d expected 0", done_cnt); end
    checks++;
    if (rst_active != 0) begin errors++; $display("FAIL arst_stays_idle: got %0d active cycles expected 0", rst_active); end
    checks++;
    if (!finished || b_addr.size() != 7) begin
      errors++; $display("FAIL arst_count: got %0d beats expected 7", b_addr.size());
    end
  endtask

  task automatic test_start_ignored();
    fill_mem(1);
    build_model(0);
    run(0, 0, 0, 5, -1, -1, 200);
    checks++;
    if (b_addr.size() != NREG || done_cnt != 1 || done_cycle != 2 * NREG) begin
      errors++; $display("FAIL restart_ignored: got %0d beats done@%0d expected %0d done@%0d",
                         b_addr.size(), done_cycle, NREG, 2 * NREG);
    end
    for (int i = 0; i < e_addr.size() && i < b_addr.size(); i++) begin
      checks++;
      if (b_addr[i] !== e_addr[i] || b_data[i] !== e_data[i]) begin
        errors++;
        $display("FAIL ignored_beat%0d: got %0h/%0h expected %0h/%0h", i, b_addr[i], b_data[i], e_addr[i], e_data[i]);
      end
    end
  endtask

  task automatic test_start_held();
    fill_mem(0);
    run(0, 0, 1, -1, -1, -1, 200);
    checks++;
    if (!finished || done_cnt != 1 || done_cycle != 2 * NREG) begin
      errors++; $display("FAIL held_done: got %0d done@%0d expected 1 done@%0d", done_cnt, done_cycle, 2 * NREG);
    end
    checks++;
    if (busy_fall != 2 * NREG + 1) begin
      errors++; $display("FAIL held_busy_gap: got %0d expected %0d", busy_fall, 2 * NREG + 1);
    end
    checks++;
    if (b_addr.size() != NREG + 1) begin
      errors++; $display("FAIL held_count: got %0d expected %0d", b_addr.size(), NREG + 1);
    end else if (b_addr[NREG] !== AW'(0) || b_data[NREG] !== mem[0]) begin
      errors++; $display("FAIL held_second_dump: got %0h/%0h expected 0/%0h", b_addr[NREG], b_data[NREG], mem[0]);
    end
  endtask

  task automatic test_skip_r0();
    fill_mem(1);
    build_model(1);
    run(1, 0, 0, -1, -1, -1, 200);
    checks++;
    if (b_addr.size() != NREG - 1 || done_cnt != 1 || done_cycle != 2 * (NREG - 1)) begin
      errors++; $display("FAIL skip_count: got %0d beats done@%0d expected %0d done@%0d",
                         b_addr.size(), done_cycle, NREG - 1, 2 * (NREG - 1));
    end
    for (int i = 0; i < e_addr.size() && i < b_addr.size(); i++) begin
      checks++;
      if (b_addr[i] !== e_addr[i] || b_data[i] !== e_data[i]) begin
        errors++;
        $display("FAIL skip_beat%0d: got %0h/%0h expected %0h/%0h", i, b_addr[i], b_data[i], e_addr[i], e_data[i]);
      end
    end
    checks++;
    if (count_last() != 1 || b_last.size() == 0 || !b_last[b_last.size() - 1]) begin
      errors++; $display("FAIL skip_last: got %0d last beats expected 1 on final", count_last());
    end
  endtask

  task automatic test_random_ready();
    for (int r = 0; r < 3; r++) begin
      fill_mem(1);
      build_model(0);
      run(0, 1, 0, -1, -1, -1, 600);
      checks++;
      if (!finished || b_addr.size() != NREG || done_cnt != 1) begin
        errors++; $display("FAIL rand%0d_count: got %0d beats %0d done expected %0d/1", r, b_addr.size(), done_cnt, NREG);
      end
      for (int i = 0; i < e_addr.size() && i < b_addr.size(); i++) begin
        checks++;
        if (b_addr[i] !== e_addr[i] || b_data[i] !== e_data[i]) begin
          errors++;
          $display("FAIL rand%0d_beat%0d: got %0h/%0h expected %0h/%0h", r, i, b_addr[i], b_data[i], e_addr[i], e_data[i]);
        end
      end
      checks++;
      if (count_last() != 1 || last_idle_bad != 0) begin
        errors++; $display("FAIL rand%0d_last: got %0d last beats %0d stray expected 1/0", r, count_last(), last_idle_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_start_ignored();
    test_start_held();
    test_skip_r0();
    test_random_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
